// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter on the CPU data bus.
// The CPU pushes bytes into a TX FIFO and a serializer sends them LSB-first
// as 8N1 frames, using a programmable clocks-per-bit divisor.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (STATUS bit4 then reads 1).
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  input  logic        we,
  input  logic [3:0]  mask,
  output logic [31:0] readData,
  output logic        hit,
  output logic        txd,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txStateT;
  localparam logic PARITY_PRESENT = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  // A zero divisor would never let a bit end, so it is treated as one clock.
  function automatic logic [15:0] clampDivisor(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       headByte;

  // Bus decode
  logic [1:0]  regSel;
  logic        regWrite;
  logic        pushReq;
  logic        pushOk;
  logic        clearOvr;
  logic        overrun;
  logic [15:0] divisor;
  logic [15:0] divEff;
  logic [31:0] statusWord;

  // Serializer state
  txStateT     state;
  txStateT     stateNext;
  logic [15:0] bitCnt;
  logic [15:0] bitCntNext;
  logic [15:0] divLatched;
  logic [15:0] divLatchedNext;
  logic [2:0]  bitIdx;
  logic [2:0]  bitIdxNext;
  logic [7:0]  shiftReg;
  logic [7:0]  shiftRegNext;
  logic        bitDone;
  logic        pop;
  logic        txdNext;
`ifdef UART_TX_PARITY_EN
  logic        parityBit;
  logic        parityBitNext;
`endif

  // Bus fields that this register window never looks at.
  logic unusedBits;
  assign unusedBits = ^{addr[1:0], writeData[31:16], mask[3:2]};

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign regSel   = addr[3:2];
  assign regWrite = we & hit;
  assign pushReq  = regWrite & (regSel == REG_DATA) & mask[0];
  assign clearOvr = regWrite & (regSel == REG_STATUS) & mask[0] & writeData[3];

  assign fifoFull  = (count == FULL_CNT);
  assign fifoEmpty = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pushOk    = pushReq & (~fifoFull | pop);
  assign headByte  = fifoMem[rdPtr];

  assign divEff  = clampDivisor(divisor);
  assign bitDone = (bitCnt == 16'd0);
  assign irq     = fifoEmpty & (state == IDLE);

  // Register writes: byte-lane DIVISOR updates and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= DIV_RESET;
      overrun <= 1'b0;
    end else begin
      if (regWrite && (regSel == REG_DIVISOR)) begin
        if (mask[0]) divisor[7:0]  <= writeData[7:0];
        if (mask[1]) divisor[15:8] <= writeData[15:8];
      end
      if (pushReq && !pushOk) begin
        overrun <= 1'b1;
      end else if (clearOvr) begin
        overrun <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)    rdPtr <= rdPtr + PTR_W'(1);
      case ({pushOk, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= writeData[7:0];
  end

  // Serializer next-state logic; txd is computed for the next state so the
  // registered output changes exactly when the state does.
  always_comb begin
    stateNext      = state;
    bitCntNext     = bitCnt;
    bitIdxNext     = bitIdx;
    shiftRegNext   = shiftReg;
    divLatchedNext = divLatched;
    pop            = 1'b0;
    txdNext        = 1'b1;
`ifdef UART_TX_PARITY_EN
    parityBitNext  = parityBit;
`endif

    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop            = 1'b1;
          shiftRegNext   = headByte;
          divLatchedNext = divEff;
          bitCntNext     = divEff - 16'd1;
`ifdef UART_TX_PARITY_EN
          parityBitNext  = evenParity(headByte);
`endif
          stateNext      = START;
        end
      end

      START: begin
        if (bitDone) begin
          bitCntNext = divLatched - 16'd1;
          bitIdxNext = 3'd0;
          stateNext  = DATA;
        end else begin
          bitCntNext = bitCnt - 16'd1;
        end
      end

      DATA: begin
        if (bitDone) begin
          bitCntNext = divLatched - 16'd1;
          if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitIdxNext   = bitIdx + 3'd1;
            shiftRegNext = {1'b0, shiftReg[7:1]};
          end
        end else begin
          bitCntNext = bitCnt - 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitDone) begin
          bitCntNext = divLatched - 16'd1;
          stateNext  = STOP;
        end else begin
          bitCntNext = bitCnt - 16'd1;
        end
      end
`endif

      STOP: begin
        if (bitDone) begin
          if (!fifoEmpty) begin
            // Chain straight into the next frame with no idle cycle.
            pop            = 1'b1;
            shiftRegNext   = headByte;
            divLatchedNext = divEff;
            bitCntNext     = divEff - 16'd1;
`ifdef UART_TX_PARITY_EN
            parityBitNext  = evenParity(headByte);
`endif
            stateNext      = START;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          bitCntNext = bitCnt - 16'd1;
        end
      end

      default: stateNext = IDLE;
    endcase

    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftRegNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txdNext = parityBitNext;
`endif
      default: txdNext = 1'b1;
    endcase
  end

  // Serializer control registers; reset aborts any frame and forces txd high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= 16'd0;
      bitIdx     <= 3'd0;
      divLatched <= 16'd1;
      txd        <= 1'b1;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      bitIdx     <= bitIdxNext;
      divLatched <= divLatchedNext;
      txd        <= txdNext;
    end
  end

  // Shift data path; it is only meaningful after a pop loads it.
  always_ff @(posedge clk) begin
    shiftReg  <= shiftRegNext;
`ifdef UART_TX_PARITY_EN
    parityBit <= parityBitNext;
`endif
  end

  // STATUS word assembly; the count field starts at bit 8.
  always_comb begin
    statusWord              = '0;
    statusWord[0]           = (state != IDLE);
    statusWord[1]           = fifoFull;
    statusWord[2]           = fifoEmpty;
    statusWord[3]           = overrun;
    statusWord[4]           = PARITY_PRESENT;
    statusWord[8 +: CNT_W]  = count;
  end

  // Combinational read mux so single-cycle loads see current state.
  always_comb begin
    readData = '0;
    if (hit) begin
      case (regSel)
        REG_STATUS:  readData = statusWord;
        REG_DIVISOR: readData = {16'd0, divisor};
        default:     readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a serial monitor decodes every frame on
// txd cycle by cycle and compares it against a scoreboard of queued bytes.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'hF000_0000;
  localparam logic [31:0] A_DATA = BASE + 32'd0;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_RSVD = BASE + 32'd12;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PAR_FLAG   = 32'h10;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PAR_FLAG   = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] writeData = '0;
  logic        we = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] readData;
  logic        hit;
  logic        txd;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] sbQ[$];       // {effective divisor, byte}
  int          startLog[$];  // cycle number of each detected start bit
  int          cycleCnt = 0;
  bit          inFrame = 1'b0;
  int          curDiv = 868;

  uart_tx_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writeData (writeData),
    .we        (we),
    .mask      (mask),
    .readData  (readData),
    .hit       (hit),
    .txd       (txd),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic busDrive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a; writeData = d; mask = m; we = 1'b1;
  endtask

  task automatic busIdle();
    @(negedge clk);
    we = 1'b0; mask = 4'h0; writeData = '0; addr = '0;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    busDrive(a, d, m);
    busIdle();
  endtask

  task automatic readReg(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0; mask = 4'h0;
    #1;
    d = readData;
  endtask

  task automatic setDiv(input int d);
    busWrite(A_DIV, 32'(d), 4'b0011);
    curDiv = d;
  endtask

  function automatic logic [23:0] sbEntry(input logic [7:0] b);
    logic [15:0] ed;
    ed = (curDiv == 0) ? 16'd1 : 16'(curDiv);
    return {ed, b};
  endfunction

  task automatic sendByte(input logic [7:0] b);
    sbQ.push_back(sbEntry(b));
    busWrite(A_DATA, {24'd0, b}, 4'h1);
  endtask

  // Count consecutive cycles with STATUS.busy set, starting now.
  task automatic countBusy(output int n);
    logic [31:0] v;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      readReg(A_STAT, v);
      if (v[0]) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (sbQ.size() == 0 && !inFrame && irq === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkVal("drain", 32'(done), 32'd1);
  endtask

  // Serial monitor: checks every cycle of each frame against the expected waveform.
  initial begin : monitor
    logic [23:0] expEnt;
    logic [7:0]  got;
    logic        lvl;
    int          d;
    int          frameLen;
    int          waveErr;
    int          b;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        startLog.push_back(cycleCnt);
        inFrame = 1'b1;
        if (sbQ.size() == 0) begin
          checkVal("unexpectedFrame", 32'd1, 32'd0);
          expEnt = 24'h0001_00;
        end else begin
          expEnt = sbQ.pop_front();
        end
        d        = int'(expEnt[23:8]);
        frameLen = FRAME_BITS * d;
        waveErr  = 0;
        got      = 8'h00;
        aborted  = 1'b0;
        for (int c = 0; c < frameLen; c++) begin
          if (c > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          b = c / d;
          if (b == 0)                    lvl = 1'b0;
          else if (b <= 8)               lvl = expEnt[b-1];
          else if (FRAME_BITS == 11 && b == 9) lvl = ^expEnt[7:0];
          else                           lvl = 1'b1;
          if (txd !== lvl) waveErr++;
          if (b >= 1 && b <= 8 && (c % d) == d / 2) got[b-1] = txd;
        end
        inFrame = 1'b0;
        if (!aborted) begin
          checkVal("rxByte", {24'd0, got}, {24'd0, expEnt[7:0]});
          checkVal("rxWave", 32'(waveErr), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] v;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("txdInReset", {31'd0, txd}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    readReg(A_STAT, v);
    checkVal("statusReset", v, 32'h4 | PAR_FLAG);
    checkVal("hitStatus", {31'd0, hit}, 32'd1);
    checkVal("txdIdle", {31'd0, txd}, 32'd1);
    checkVal("irqReset", {31'd0, irq}, 32'd1);
    readReg(A_DIV, v);
    checkVal("divReset", v, 32'd868);
    readReg(A_DATA, v);
    checkVal("dataReads0", v, 32'd0);
    readReg(A_RSVD, v);
    checkVal("rsvdReads0", v, 32'd0);
    readReg(32'h1000_0004, v);
    checkVal("missData", v, 32'd0);
    checkVal("missHit", {31'd0, hit}, 32'd0);

    // Single frame 0xA5 at divisor 4
    setDiv(4);
    readReg(A_DIV, v);
    checkVal("divWrite", v, 32'd4);
    sendByte(8'hA5);
    countBusy(n);
    checkVal("busyA5", 32'(n), 32'(FRAME_BITS * 4));
    checkVal("irqAfterA5", {31'd0, irq}, 32'd1);
    waitDrain(100);

    // Masked writes: mask 0 does nothing, byte lanes are independent
    busWrite(A_DATA, 32'h55, 4'h0);
    readReg(A_STAT, v);
    checkVal("mask0Push", v, 32'h4 | PAR_FLAG);
    busWrite(A_DIV, 32'hABCD_1200, 4'b0010);
    readReg(A_DIV, v);
    checkVal("divLane1", v, 32'h1204);
    busWrite(A_DIV, 32'h77, 4'h0);
    readReg(A_DIV, v);
    checkVal("divMask0", v, 32'h1204);
    setDiv(4);

    // Nine-byte burst fills the FIFO, a tenth overruns
    for (int i = 0; i < 9; i++) begin
      sbQ.push_back(sbEntry(8'(8'h10 + i * 8'h11)));
      busDrive(A_DATA, 32'(8'h10 + i * 8'h11), 4'h1);
    end
    busIdle();
    readReg(A_STAT, v);
    checkVal("statusFull", v, 32'h0803 | PAR_FLAG);
    busWrite(A_DATA, 32'hEE, 4'h1);
    readReg(A_STAT, v);
    checkVal("statusOverrun", v, 32'h080B | PAR_FLAG);
    busWrite(A_STAT, 32'h8, 4'h1);
    readReg(A_STAT, v);
    checkVal("overrunClear", v, 32'h0803 | PAR_FLAG);
    waitDrain(1000);

    // Two back-to-back frames with no gap
    startLog.delete();
    sbQ.push_back(sbEntry(8'hC3));
    busDrive(A_DATA, 32'hC3, 4'h1);
    sbQ.push_back(sbEntry(8'h3C));
    busDrive(A_DATA, 32'h3C, 4'h1);
    busIdle();
    countBusy(n);
    checkVal("busyPair", 32'(n), 32'(2 * FRAME_BITS * 4));
    waitDrain(100);
    checkVal("pairStarts", 32'(startLog.size()), 32'd2);
    if (startLog.size() == 2)
      checkVal("pairGap", 32'(startLog[1] - startLog[0]), 32'(FRAME_BITS * 4));

    // Divisor 0 behaves as one clock per bit
    setDiv(0);
    readReg(A_DIV, v);
    checkVal("divZeroRead", v, 32'd0);
    sendByte(8'h00);
    countBusy(n);
    checkVal("busyDiv0", 32'(n), 32'(FRAME_BITS));
    waitDrain(100);
    sendByte(8'h81);
    waitDrain(100);

    // Reset in the middle of the data bits
    setDiv(4);
    sendByte(8'h00);
    repeat (8) @(negedge clk);
    checkVal("txdMidData", {31'd0, txd}, 32'd0);
    #2 reset = 1'b1;
    #1 checkVal("txdAsyncReset", {31'd0, txd}, 32'd1);
    readReg(A_STAT, v);
    checkVal("statusInReset", v, 32'h4 | PAR_FLAG);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbQ.delete();
    curDiv = 868;
    readReg(A_DIV, v);
    checkVal("divAfterReset", v, 32'd868);
    readReg(A_STAT, v);
    checkVal("statusAfterReset", v, 32'h4 | PAR_FLAG);
    checkVal("irqAfterReset", {31'd0, irq}, 32'd1);
    checkVal("txdAfterReset", {31'd0, txd}, 32'd1);

    // Recovery frame after reset
    setDiv(2);
    sendByte(8'h5A);
    waitDrain(200);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
